sd_wbm_arbiter: RTL and testbench

SD_WBM_ARBITER -- requirements
Module: sd_wbm_arbiter

---
 rtl/sd_wbm_arbiter_if.sv | 52 +++++
 rtl/sd_wbm_arbiter.sv | 119 +++++++++++
 tb/tb_sd_wbm_arbiter.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_wbm_arbiter_if.sv
// Bus bundle between the TX/RX fillers, the arbiter and the shared Wishbone slave.
// The master modport is the arbiter's view; slave is the surrounding environment.
interface sd_wbm_arbiter_if #(
  parameter int unsigned ADR_W = 32
);
  logic             tx_cyc_i;
  logic             tx_stb_i;
  logic             tx_we_i;
  logic [ADR_W-1:0] tx_adr_i;
  logic [2:0]       tx_cti_i;
  logic [1:0]       tx_bte_i;
  logic             tx_ack_o;

  logic             rx_cyc_i;
  logic             rx_stb_i;
  logic             rx_we_i;
  logic [ADR_W-1:0] rx_adr_i;
  logic [2:0]       rx_cti_i;
  logic [1:0]       rx_bte_i;
  logic [31:0]      rx_dat_i;
  logic             rx_ack_o;

  logic             m_wb_cyc_o;
  logic             m_wb_stb_o;
  logic             m_wb_we_o;
  logic [ADR_W-1:0] m_wb_adr_o;
  logic [3:0]       m_wb_sel_o;
  logic [2:0]       m_wb_cti_o;
  logic [1:0]       m_wb_bte_o;
  logic [31:0]      m_wb_dat_o;
  logic             m_wb_ack_i;

  modport master (
    input  tx_cyc_i, tx_stb_i, tx_we_i, tx_adr_i, tx_cti_i, tx_bte_i,
    output tx_ack_o,
    input  rx_cyc_i, rx_stb_i, rx_we_i, rx_adr_i, rx_cti_i, rx_bte_i, rx_dat_i,
    output rx_ack_o,
    output m_wb_cyc_o, m_wb_stb_o, m_wb_we_o, m_wb_adr_o, m_wb_sel_o,
    output m_wb_cti_o, m_wb_bte_o, m_wb_dat_o,
    input  m_wb_ack_i
  );

  modport slave (
    output tx_cyc_i, tx_stb_i, tx_we_i, tx_adr_i, tx_cti_i, tx_bte_i,
    input  tx_ack_o,
    output rx_cyc_i, rx_stb_i, rx_we_i, rx_adr_i, rx_cti_i, rx_bte_i, rx_dat_i,
    input  rx_ack_o,
    input  m_wb_cyc_o, m_wb_stb_o, m_wb_we_o, m_wb_adr_o, m_wb_sel_o,
    input  m_wb_cti_o, m_wb_bte_o, m_wb_dat_o,
    output m_wb_ack_i
  );
endinterface

// File: rtl/sd_wbm_arbiter.sv
// Round-robin arbiter sharing one Wishbone master port between the SD TX and RX
// fillers, with a stall timeout that drops the bus into an error state.
module sd_wbm_arbiter #(
  parameter logic [15:0] TO_CYCLES = 16'd1024,
  parameter int unsigned ADR_W     = 32
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  sd_wbm_arbiter_if.master   bus,
  output logic               tx_gnt_o,
  output logic               rx_gnt_o,
  output logic               to_err_o
);

  typedef enum logic [1:0] {IDLE, GNT_TX, GNT_RX, ERR} state_t;

  localparam logic [15:0] TO_LAST = TO_CYCLES - 16'd1;

  state_t      state, state_nxt;
  logic        last_rx, last_rx_nxt;
  logic        err_rx, err_rx_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic        to_err_nxt;
  logic        gnt_cyc, gnt_stb;
  logic [ADR_W-1:0] adr_mux;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state    <= IDLE;
      last_rx  <= 1'b1;
      err_rx   <= 1'b0;
      cnt      <= '0;
      to_err_o <= 1'b0;
    end else begin
      state    <= state_nxt;
      last_rx  <= last_rx_nxt;
      err_rx   <= err_rx_nxt;
      cnt      <= cnt_nxt;
      to_err_o <= to_err_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    last_rx_nxt = last_rx;
    err_rx_nxt  = err_rx;
    cnt_nxt     = '0;
    to_err_nxt  = 1'b0;
    gnt_cyc     = (state == GNT_RX) ? bus.rx_cyc_i : bus.tx_cyc_i;
    gnt_stb     = (state == GNT_RX) ? bus.rx_stb_i : bus.tx_stb_i;
    case (state)
      IDLE: begin
        if (bus.tx_cyc_i && bus.rx_cyc_i) state_nxt = last_rx ? GNT_TX : GNT_RX;
        else if (bus.tx_cyc_i)            state_nxt = GNT_TX;
        else if (bus.rx_cyc_i)            state_nxt = GNT_RX;
      end
      GNT_TX, GNT_RX: begin
        if (!gnt_cyc) begin
          state_nxt   = IDLE;
          last_rx_nxt = (state == GNT_RX);
        end else if (gnt_stb && !bus.m_wb_ack_i) begin
          // Counter holds stall cycles already elapsed; the TO_CYCLES-th one trips.
          if (cnt == TO_LAST) begin
            state_nxt  = ERR;
            err_rx_nxt = (state == GNT_RX);
            to_err_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + 16'd1;
          end
        end
      end
      ERR: begin
        if (err_rx ? !bus.rx_cyc_i : !bus.tx_cyc_i) begin
          state_nxt   = IDLE;
          last_rx_nxt = err_rx;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.m_wb_cyc_o = 1'b0;
    bus.m_wb_stb_o = 1'b0;
    bus.m_wb_we_o  = 1'b0;
    adr_mux        = '0;
    bus.m_wb_cti_o = '0;
    bus.m_wb_bte_o = '0;
    bus.m_wb_dat_o = '0;
    case (state)
      GNT_TX: begin
        bus.m_wb_cyc_o = bus.tx_cyc_i;
        bus.m_wb_stb_o = bus.tx_stb_i;
        bus.m_wb_we_o  = bus.tx_we_i;
        adr_mux        = bus.tx_adr_i;
        bus.m_wb_cti_o = bus.tx_cti_i;
        bus.m_wb_bte_o = bus.tx_bte_i;
      end
      GNT_RX: begin
        bus.m_wb_cyc_o = bus.rx_cyc_i;
        bus.m_wb_stb_o = bus.rx_stb_i;
        bus.m_wb_we_o  = bus.rx_we_i;
        adr_mux        = bus.rx_adr_i;
        bus.m_wb_cti_o = bus.rx_cti_i;
        bus.m_wb_bte_o = bus.rx_bte_i;
        bus.m_wb_dat_o = bus.rx_dat_i;
      end
      default: ;
    endcase
  end

  assign bus.m_wb_adr_o = adr_mux;
  assign bus.m_wb_sel_o = 4'b1111;
  assign tx_gnt_o       = (state == GNT_TX);
  assign rx_gnt_o       = (state == GNT_RX);
  assign bus.tx_ack_o   = bus.m_wb_ack_i && (state == GNT_TX);
  assign bus.rx_ack_o   = bus.m_wb_ack_i && (state == GNT_RX);

endmodule

// File: tb/tb_sd_wbm_arbiter.sv
// Bench for sd_wbm_arbiter: directed vector table, multi-cycle scenarios and a
// randomized run checked against an ownership/stall-count reference model.
module tb_sd_wbm_arbiter;

  localparam int TO = 8;
  localparam logic [31:0] TXA = 32'h0000_1000;
  localparam logic [31:0] RXA = 32'h0000_2000;
  localparam logic [31:0] RXD = 32'hDEAD_BEEF;

  logic wb_clk_i = 1'b0;
  logic wb_rst_i = 1'b1;
  logic tx_gnt_o, rx_gnt_o, to_err_o;

  sd_wbm_arbiter_if #(.ADR_W(32)) bus ();

  sd_wbm_arbiter #(.TO_CYCLES(16'(TO)), .ADR_W(32)) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .bus      (bus),
    .tx_gnt_o (tx_gnt_o),
    .rx_gnt_o (rx_gnt_o),
    .to_err_o (to_err_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: who owns the bus (0 none, 1 TX, 2 RX), error holder,
  // last served requester and consecutive stall cycles seen by the owner.
  int m_owner, m_err_who, m_last, m_stalls;
  bit m_err, m_to_err;

  typedef struct {
    logic rst, tc, ts, rc, rs, ack;
    logic tg, rg, cyc, ta, ra, te;
    logic [31:0] adr;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic cyc_of(input int who);
    return (who == 1) ? bus.tx_cyc_i : bus.rx_cyc_i;
  endfunction

  function automatic logic stb_of(input int who);
    return (who == 1) ? bus.tx_stb_i : bus.rx_stb_i;
  endfunction

  task automatic model_step();
    if (wb_rst_i) begin
      m_owner = 0; m_err = 0; m_err_who = 0; m_last = 2; m_stalls = 0; m_to_err = 0;
      return;
    end
    m_to_err = 0;
    if (m_err) begin
      if (!cyc_of(m_err_who)) begin
        m_err  = 0;
        m_last = m_err_who;
      end
    end else if (m_owner == 0) begin
      if (bus.tx_cyc_i && bus.rx_cyc_i) m_owner = (m_last == 2) ? 1 : 2;
      else if (bus.tx_cyc_i)            m_owner = 1;
      else if (bus.rx_cyc_i)            m_owner = 2;
      m_stalls = 0;
    end else if (!cyc_of(m_owner)) begin
      m_last   = m_owner;
      m_owner  = 0;
      m_stalls = 0;
    end else if (stb_of(m_owner) && !bus.m_wb_ack_i) begin
      m_stalls++;
      if (m_stalls == TO) begin
        m_err     = 1;
        m_err_who = m_owner;
        m_owner   = 0;
        m_stalls  = 0;
        m_to_err  = 1;
      end
    end else begin
      m_stalls = 0;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic check_model();
    logic ecyc, estb, ewe;
    logic [31:0] eadr, edat;
    logic [2:0] ecti;
    logic [1:0] ebte;
    ecyc = 0; estb = 0; ewe = 0; eadr = '0; edat = '0; ecti = '0; ebte = '0;
    if (m_owner == 1) begin
      ecyc = bus.tx_cyc_i; estb = bus.tx_stb_i; ewe = bus.tx_we_i;
      eadr = bus.tx_adr_i; ecti = bus.tx_cti_i; ebte = bus.tx_bte_i;
    end else if (m_owner == 2) begin
      ecyc = bus.rx_cyc_i; estb = bus.rx_stb_i; ewe = bus.rx_we_i;
      eadr = bus.rx_adr_i; ecti = bus.rx_cti_i; ebte = bus.rx_bte_i;
      edat = bus.rx_dat_i;
    end
    chk("m_cyc", bus.m_wb_cyc_o, ecyc);
    chk("m_stb", bus.m_wb_stb_o, estb);
    chk("m_we", bus.m_wb_we_o, ewe);
    chk("m_adr", bus.m_wb_adr_o, eadr);
    chk("m_cti", bus.m_wb_cti_o, ecti);
    chk("m_bte", bus.m_wb_bte_o, ebte);
    chk("m_dat", bus.m_wb_dat_o, edat);
    chk("m_sel", bus.m_wb_sel_o, 4'hF);
    chk("tx_ack", bus.tx_ack_o, bus.m_wb_ack_i && m_owner == 1);
    chk("rx_ack", bus.rx_ack_o, bus.m_wb_ack_i && m_owner == 2);
    chk("tx_gnt", tx_gnt_o, m_owner == 1);
    chk("rx_gnt", rx_gnt_o, m_owner == 2);
    chk("to_err", to_err_o, m_to_err);
  endtask

  task automatic clear_inputs();
    bus.tx_cyc_i = 0; bus.tx_stb_i = 0; bus.tx_we_i = 0; bus.tx_adr_i = TXA;
    bus.tx_cti_i = 3'b000; bus.tx_bte_i = 2'b00;
    bus.rx_cyc_i = 0; bus.rx_stb_i = 0; bus.rx_we_i = 1; bus.rx_adr_i = RXA;
    bus.rx_cti_i = 3'b000; bus.rx_bte_i = 2'b00; bus.rx_dat_i = RXD;
    bus.m_wb_ack_i = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    wb_rst_i = 1;
    tick();
    wb_rst_i = 0;
  endtask

  initial begin
    int k, acks, rxacks, exp_owner;
    clear_inputs();
    wb_rst_i = 1;
    tick();
    tick();
    wb_rst_i = 0;
    chk("rst_to_err", to_err_o, 1'b0);
    chk("rst_cyc", bus.m_wb_cyc_o, 1'b0);

    // rst tc ts rc rs ack | tg rg cyc ta ra te adr
    tbl[0]  = '{0,1,1,1,1,0, 0,0,0,0,0,0, 32'h0};
    tbl[1]  = '{0,1,1,1,1,1, 1,0,1,1,0,0, TXA};
    tbl[2]  = '{0,0,0,1,1,0, 1,0,0,0,0,0, TXA};
    tbl[3]  = '{0,0,0,1,1,0, 0,0,0,0,0,0, 32'h0};
    tbl[4]  = '{0,0,0,1,1,1, 0,1,1,0,1,0, RXA};
    tbl[5]  = '{0,0,0,0,0,1, 0,1,0,0,1,0, RXA};
    tbl[6]  = '{0,0,0,0,0,1, 0,0,0,0,0,0, 32'h0};
    tbl[7]  = '{0,1,0,0,0,1, 0,0,0,0,0,0, 32'h0};
    tbl[8]  = '{0,1,1,1,1,0, 1,0,1,0,0,0, TXA};
    tbl[9]  = '{0,1,1,1,1,0, 1,0,1,0,0,0, TXA};
    tbl[10] = '{1,1,1,1,1,0, 1,0,1,0,0,0, TXA};
    tbl[11] = '{0,1,1,1,1,0, 0,0,0,0,0,0, 32'h0};
    for (int i = 0; i < 12; i++) begin
      wb_rst_i = tbl[i].rst;
      bus.tx_cyc_i = tbl[i].tc; bus.tx_stb_i = tbl[i].ts;
      bus.rx_cyc_i = tbl[i].rc; bus.rx_stb_i = tbl[i].rs;
      bus.m_wb_ack_i = tbl[i].ack;
      #1;
      chk($sformatf("t%0d_tx_gnt", i), tx_gnt_o, tbl[i].tg);
      chk($sformatf("t%0d_rx_gnt", i), rx_gnt_o, tbl[i].rg);
      chk($sformatf("t%0d_cyc", i), bus.m_wb_cyc_o, tbl[i].cyc);
      chk($sformatf("t%0d_tx_ack", i), bus.tx_ack_o, tbl[i].ta);
      chk($sformatf("t%0d_rx_ack", i), bus.rx_ack_o, tbl[i].ra);
      chk($sformatf("t%0d_to_err", i), to_err_o, tbl[i].te);
      chk($sformatf("t%0d_adr", i), bus.m_wb_adr_o, tbl[i].adr);
      chk($sformatf("t%0d_dat", i), bus.m_wb_dat_o, tbl[i].rg ? RXD : 32'h0);
      chk($sformatf("t%0d_sel", i), bus.m_wb_sel_o, 4'hF);
      tick();
    end
    wb_rst_i = 0;

    // TX 4-beat burst while RX keeps requesting
    do_reset();
    bus.tx_cyc_i = 1; bus.tx_stb_i = 1; bus.tx_cti_i = 3'b010;
    bus.rx_cyc_i = 1; bus.rx_stb_i = 1;
    tick();
    chk("burst_tx_gnt", tx_gnt_o, 1'b1);
    acks = 0; rxacks = 0;
    for (int b = 0; b < 4; b++) begin
      bus.tx_cti_i = (b == 3) ? 3'b111 : 3'b010;
      bus.m_wb_ack_i = 1;
      #1;
      if (bus.tx_ack_o === 1'b1) acks++;
      if (bus.rx_ack_o !== 1'b0) rxacks++;
      chk("burst_cti", bus.m_wb_cti_o, bus.tx_cti_i);
      tick();
    end
    bus.tx_cyc_i = 0; bus.tx_stb_i = 0; bus.m_wb_ack_i = 0;
    #1;
    if (bus.rx_ack_o !== 1'b0) rxacks++;
    chk("burst_tx_acks", acks, 4);
    tick();
    chk("burst_dead_rx_gnt", rx_gnt_o, 1'b0);
    tick();
    chk("burst_rx_gnt", rx_gnt_o, 1'b1);
    chk("burst_rx_dat", bus.m_wb_dat_o, RXD);
    chk("burst_rx_acks", rxacks, 0);

    // Alternating simultaneous requests
    do_reset();
    for (int a = 0; a < 6; a++) begin
      bus.tx_cyc_i = 1; bus.rx_cyc_i = 1;
      tick();
      exp_owner = (a % 2 == 0) ? 1 : 2;
      chk($sformatf("rr%0d_tx_gnt", a), tx_gnt_o, exp_owner == 1);
      chk($sformatf("rr%0d_rx_gnt", a), rx_gnt_o, exp_owner == 2);
      bus.tx_cyc_i = 0; bus.rx_cyc_i = 0;
      tick();
    end

    // Timeout: RX stalls with no ack
    do_reset();
    bus.rx_cyc_i = 1; bus.rx_stb_i = 1;
    k = 0;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (to_err_o === 1'b1) begin
        k = c;
        break;
      end
    end
    chk("to_latency", k, TO + 1);
    chk("to_err_cyc", bus.m_wb_cyc_o, 1'b0);
    chk("to_err_rx_gnt", rx_gnt_o, 1'b0);
    bus.m_wb_ack_i = 1;
    tick();
    chk("to_pulse_once", to_err_o, 1'b0);
    chk("to_err_rx_ack", bus.rx_ack_o, 1'b0);
    bus.m_wb_ack_i = 0;
    bus.rx_cyc_i = 0; bus.rx_stb_i = 0;
    tick();
    bus.rx_cyc_i = 1;
    tick();
    chk("to_regrant_rx", rx_gnt_o, 1'b1);

    // Reset in the middle of an RX burst
    do_reset();
    bus.rx_cyc_i = 1; bus.rx_stb_i = 1; bus.m_wb_ack_i = 1; bus.rx_cti_i = 3'b010;
    tick();
    tick();
    chk("mid_rx_gnt", rx_gnt_o, 1'b1);
    wb_rst_i = 1;
    tick();
    chk("mid_rst_cyc", bus.m_wb_cyc_o, 1'b0);
    chk("mid_rst_rx_gnt", rx_gnt_o, 1'b0);
    chk("mid_rst_rx_ack", bus.rx_ack_o, 1'b0);
    wb_rst_i = 0;
    bus.rx_cyc_i = 0; bus.rx_stb_i = 0; bus.m_wb_ack_i = 0;
    bus.tx_cyc_i = 1; bus.tx_stb_i = 1;
    tick();
    chk("mid_after_tx_gnt", tx_gnt_o, 1'b1);

    // Randomized run against the reference model
    do_reset();
    for (int r = 0; r < 1500; r++) begin
      wb_rst_i = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 5) == 0) bus.tx_cyc_i = ~bus.tx_cyc_i;
      if ($urandom_range(0, 5) == 0) bus.rx_cyc_i = ~bus.rx_cyc_i;
      bus.tx_stb_i = ($urandom_range(0, 3) != 0);
      bus.rx_stb_i = ($urandom_range(0, 3) != 0);
      bus.tx_we_i  = 1'($urandom);
      bus.rx_we_i  = 1'($urandom);
      bus.tx_adr_i = $urandom;
      bus.rx_adr_i = $urandom;
      bus.tx_cti_i = 3'($urandom);
      bus.rx_cti_i = 3'($urandom);
      bus.tx_bte_i = 2'($urandom);
      bus.rx_bte_i = 2'($urandom);
      bus.rx_dat_i = $urandom;
      bus.m_wb_ack_i = ($urandom_range(0, 4) == 0);
      #1;
      check_model();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
